// File: rtl/line_scan_sequencer.sv
// Line scan sequencer: steps a 3-bit decoder select with blanking and a programmable dwell,
// sampling a shared sense input per line. Optional macro SENSE_SYNC_EN adds a 2-flop sense synchronizer.
module line_scan_sequencer #(
   parameter int unsigned DWELL_W      = 8,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell_cycles,
   input  logic               sense_in,
   output logic [2:0]         sel_out,
   output logic               sel_en,
   output logic [7:0]         hit_vec,
   output logic               frame_done,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   state_t             state;
   logic [2:0]         line;
   logic [BW-1:0]      bcnt;
   logic [DWELL_W-1:0] dcnt;
   logic [6:0]         shadow;
   logic [DWELL_W-1:0] dwell_last;
   logic               sense_s;

   // A dwell of 0 behaves as 1, so the down-counter reload is clamped at zero.
   always_comb begin
      dwell_last = '0;
      if (dwell_cycles != '0)
         dwell_last = dwell_cycles - DWELL_W'(1);
   end

`ifdef SENSE_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync <= '0;
      else
         sync <= {sync[0], sense_in};
   end

   assign sense_s = sync[1];
`else
   assign sense_s = sense_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         line       <= '0;
         bcnt       <= '0;
         dcnt       <= '0;
         shadow     <= '0;
         sel_out    <= '0;
         sel_en     <= 1'b0;
         hit_vec    <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (stop && state != IDLE) begin
            state   <= IDLE;
            line    <= '0;
            sel_out <= '0;
            sel_en  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !stop) begin
                     line    <= '0;
                     sel_out <= '0;
                     busy    <= 1'b1;
                     if (BLANK_CYCLES == 0) begin
                        state  <= DRIVE;
                        sel_en <= 1'b1;
                        dcnt   <= dwell_last;
                     end else begin
                        state  <= BLANK;
                        sel_en <= 1'b0;
                        bcnt   <= BLANK_LAST;
                     end
                  end
               end
               BLANK: begin
                  if (bcnt == '0) begin
                     state  <= DRIVE;
                     sel_en <= 1'b1;
                     dcnt   <= dwell_last;
                  end else begin
                     bcnt <= bcnt - BW'(1);
                  end
               end
               DRIVE: begin
                  if (dcnt == '0) begin
                     if (line != 3'd7) begin
                        shadow[line] <= sense_s;
                        line         <= line + 3'd1;
                        sel_out      <= line + 3'd1;
                     end else begin
                        // Bit 7 bypasses the shadow so the frame publishes in this same cycle.
                        hit_vec    <= {sense_s, shadow};
                        frame_done <= 1'b1;
                        line       <= '0;
                        sel_out    <= '0;
                     end
                     if (line == 3'd7 && !continuous) begin
                        state  <= IDLE;
                        sel_en <= 1'b0;
                        busy   <= 1'b0;
                     end else if (BLANK_CYCLES == 0) begin
                        state  <= DRIVE;
                        sel_en <= 1'b1;
                        dcnt   <= dwell_last;
                     end else begin
                        state  <= BLANK;
                        sel_en <= 1'b0;
                        bcnt   <= BLANK_LAST;
                     end
                  end else begin
                     dcnt <= dcnt - DWELL_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Self-checking bench for line_scan_sequencer (BLANK_CYCLES=2): table-driven frames plus
// hand-written reset, stop, continuous and start-while-busy sequences.
module tb_line_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       continuous = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic       sense_in = 1'b0;
   logic [2:0] sel_out;
   logic       sel_en;
   logic [7:0] hit_vec;
   logic       frame_done;
   logic       busy;

   logic [7:0] mask = 8'h00;
   int         passed = 0;
   int         total = 0;
   int         viol = 0;
   int         done_cnt = 0;

   line_scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
      .dwell_cycles(dwell), .sense_in(sense_in), .sel_out(sel_out), .sel_en(sel_en),
      .hit_vec(hit_vec), .frame_done(frame_done), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   // Sense source answers for whichever line is selected; also watches the select invariant.
   initial begin
      logic [2:0] prev_sel;
      prev_sel = 3'd0;
      forever begin
         @(negedge clk);
         sense_in = mask[sel_out];
         if (rst_n && sel_out != prev_sel && sel_en) viol++;
         if (frame_done) done_cnt++;
         prev_sel = sel_out;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      int         dwell;
      logic [7:0] mask;
      logic [7:0] exp_hit;
      int         exp_done;
      int         mid_start;
   } vec_t;

   vec_t vecs[5];

   // Entered and left on a falling edge; k counts cycles after the one that saw start.
   task automatic run_frame(input vec_t v);
      int k;
      int rise;
      dwell = 8'(v.dwell);
      mask = v.mask;
      continuous = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      rise = 0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      while (!frame_done && k < 3000) begin
         if (sel_en && rise == 0) rise = k;
         start = (v.mid_start != 0 && k == v.mid_start);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("frame_done_cycle", k, v.exp_done);
      check("hit_vec", {24'd0, hit_vec}, {24'd0, v.exp_hit});
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("sel_en_first_rise", rise, 3);
   endtask

   initial begin
      vecs[0] = '{dwell: 1,   mask: 8'hA5, exp_hit: 8'hA5, exp_done: 25,   mid_start: 0};
      vecs[1] = '{dwell: 0,   mask: 8'h01, exp_hit: 8'h01, exp_done: 25,   mid_start: 10};
      vecs[2] = '{dwell: 5,   mask: 8'h80, exp_hit: 8'h80, exp_done: 57,   mid_start: 0};
      vecs[3] = '{dwell: 255, mask: 8'hFF, exp_hit: 8'hFF, exp_done: 2057, mid_start: 0};
      vecs[4] = '{dwell: 3,   mask: 8'h24, exp_hit: 8'h24, exp_done: 41,   mid_start: 20};

      // Reset state
      @(negedge clk);
      check("rst_sel_out", {29'd0, sel_out}, 32'd0);
      check("rst_sel_en", {31'd0, sel_en}, 32'd0);
      check("rst_hit_vec", {24'd0, hit_vec}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // stop beats start in IDLE
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      check("stop_wins_over_start", {31'd0, busy}, 32'd0);

      // stop while line 4 is selected
      begin
         int n;
         int d0;
         dwell = 8'd3;
         mask = 8'hFF;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         n = 0;
         while (sel_out != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("reach_line4", {29'd0, sel_out}, 32'd4);
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
         check("stop_busy", {31'd0, busy}, 32'd0);
         check("stop_sel_en", {31'd0, sel_en}, 32'd0);
         check("stop_sel_out", {29'd0, sel_out}, 32'd0);
         check("stop_no_done", {31'd0, frame_done}, 32'd0);
         d0 = done_cnt;
         repeat (60) @(negedge clk);
         check("stop_no_later_done", done_cnt - d0, 0);
         check("stop_hit_kept", {24'd0, hit_vec}, 32'h24);
      end

      // Continuous scan: frames every 24 cycles, select sequence 0..7
      begin
         int k;
         int nd;
         int se;
         int t[3];
         logic pe;
         logic [2:0] le;
         t = '{0, 0, 0};
         nd = 0;
         se = 0;
         pe = 1'b0;
         le = 3'd0;
         dwell = 8'd1;
         mask = 8'h5A;
         continuous = 1'b1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         k = 1;
         while (nd < 3 && k < 500) begin
            if (sel_en && !pe) begin
               if (sel_out !== le) se++;
               le = le + 3'd1;
            end
            pe = sel_en;
            if (frame_done) begin
               t[nd] = k;
               nd++;
            end
            if (nd < 3) begin
               @(negedge clk);
               k++;
            end
         end
         check("cont_first_done", t[0], 25);
         check("cont_period_1", t[1] - t[0], 24);
         check("cont_period_2", t[2] - t[1], 24);
         check("cont_hit_vec", {24'd0, hit_vec}, 32'h5A);
         check("cont_sel_sequence_errors", se, 0);
         check("cont_still_busy", {31'd0, busy}, 32'd1);
         continuous = 1'b0;
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end

      // Asynchronous reset mid-frame
      dwell = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_sel_en", {31'd0, sel_en}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_hit_vec", {24'd0, hit_vec}, 32'd0);
      check("async_rst_sel_out", {29'd0, sel_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_sel_en", {31'd0, sel_en}, 32'd0);

      check("sel_change_while_enabled", viol, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
